led_scan_driver: RTL
====================

Name: led_scan_driver

Overview:
- Parametrised, time-multiplexed driver for an array of NUM_DIGITS 7-segment displays with decimal points.
- Holds a double-buffered display image, decodes each 4-bit nibble to the standard hex font (0-9, A-F), and scans digits round-robin with a programmable dwell time.
- Adds a ghost-suppression blanking gap per digit, optional leading-zero suppression, per-digit blanking, and frame-synchronous image update.
- Sits between system logic and the board's segment/digit-select pins; it replaces the single-digit combinational decode path.

Parameters:
- NUM_DIGITS, 8, number of digits scanned (legal range 1..16).
- SCAN_DIV, 50000, clock cycles per digit slot (≥2).
- BLANK_CYCLES, 500, cycles at the start of each slot with all digits off (0 ≤ BLANK_CYCLES < SCAN_DIV).
- SEG_ACTIVE_LOW, 1, 1 means o_seg bits are inverted (common-anode).
- SEL_ACTIVE_LOW, 1, 1 means o_dig_sel bits are inverted.

Ports:
- i_clk, in, 1, system clock.
- i_rst, in, 1, reset; asynchronous, active-high.
- i_data, in, 4*NUM_DIGITS, hex nibble per digit; digit k = i_data[4k+3:4k]; digit 0 is rightmost/least significant.
- i_dp, in, NUM_DIGITS, decimal point per digit.
- i_blank, in, NUM_DIGITS, force digit k dark.
- i_load, in, 1, one-cycle strobe; captures i_data/i_dp/i_blank into the pending buffer.
- i_lz_en, in, 1, leading-zero suppression enable (sampled live).
- o_seg, out, 8, segments {dp,g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW.
- o_dig_sel, out, NUM_DIGITS, one-hot digit enable, polarity per SEL_ACTIVE_LOW.
- o_pending, out, 1, high while a loaded image awaits frame boundary.
- o_frame_done, out, 1, one-cycle pulse at each frame boundary.

Behaviour:
- Reset (async, active-high):
  - cnt=0, idx=0.
  - Active and pending buffers all zero; pending-valid=0.
  - o_seg and o_dig_sel at their "off" levels (all-ones when active-low).
  - o_pending=0, o_frame_done=0.
- Scan counters:
  - cnt counts 0..SCAN_DIV-1 and wraps.
  - On wrap, idx increments 0..NUM_DIGITS-1 and wraps to 0.
  - Frame length = NUM_DIGITS*SCAN_DIV cycles.
  - Boundary = the cycle with idx=NUM_DIGITS-1 and cnt=SCAN_DIV-1.
- Output registers (1-cycle latency from cnt/idx):
  - If cnt<BLANK_CYCLES, all digits off and segments off.
  - Otherwise digit idx is enabled and o_seg = font(active nibble[idx]) with bit7 = active dp[idx].
  - If digit idx is blanked (i_blank or leading-zero rule), its select is still asserted but all segments are off, dp included.
- Font (active-high, bit0=a): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 B:7C C:39 D:5E E:79 F:71.
  - Polarity inversion is applied after dp merge.
- Leading-zero suppression (i_lz_en=1), evaluated on the active buffer:
  - Digit k is suppressed when nibble=0, dp=0, and every digit j>k is also suppressed or explicitly blanked.
  - Digit 0 is never suppressed.
- Load handshake:
  - i_load=1 writes the pending buffer and sets pending-valid.
  - A load while pending-valid is already set overwrites the pending buffer; last write wins.
  - At the boundary with pending-valid=1: active ← pending and pending-valid ← 0, effective from the next cycle (the first cycle of digit 0).
  - i_load on the boundary cycle: the new inputs go directly to active, pending-valid ← 0.
  - o_pending = pending-valid (registered).
- o_frame_done: registered, high for exactly one cycle, the cycle after the boundary.
- Reset mid-frame: immediate off state; scanning restarts from idx=0, cnt=0 after deassertion; any pending image is lost.
- NUM_DIGITS=1: idx is constant 0; boundary occurs every SCAN_DIV cycles.

Test Plan:
- Params N=4, SCAN_DIV=8, BLANK=2, active-low. Reset, then load i_data=16'h0003 with no blanks, lz off → after the first boundary, digit 0 slot cycles 2-7 give o_dig_sel=4'b1110, o_seg=8'hB0; slot cycles 0-1 give o_dig_sel=4'b1111, o_seg=8'hFF.
- Load i_data=16'h00A5, i_dp=4'b0001, i_lz_en=1 → digit0 o_seg=8'h12, digit1 o_seg=8'h88, digits 2-3 o_seg=8'hFF with their selects asserted.
- Load 16'h1111 mid-frame at cycle 5 → o_pending=1 until the boundary (cycle 31); active unchanged before it; o_frame_done pulses at cycle 32 together with the new image; o_pending=0.
- Two loads (16'h2222 then 16'h3333) within one frame → only 3333 is displayed after the boundary.
- i_load asserted exactly on the boundary with 16'hFFFF → displayed from the next cycle; o_pending never rises.
- Assert i_rst at cycle 13 for 3 cycles → outputs go off asynchronously; after release, digit 0 slot restarts; the active image is 0, so digit0 shows o_seg=8'hC0.

Source files
------------

// File: rtl/led_scan_driver.sv
// Time-multiplexed hex 7-segment scanner: double-buffered image, per-slot
// ghost blanking, leading-zero suppression and frame-synchronous update.
module led_scan_driver #(
  parameter int NUM_DIGITS     = 8,
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYCLES   = 500,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int SEL_ACTIVE_LOW = 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [4*NUM_DIGITS-1:0]   i_data,
  input  logic [NUM_DIGITS-1:0]     i_dp,
  input  logic [NUM_DIGITS-1:0]     i_blank,
  input  logic                      i_load,
  input  logic                      i_lz_en,
  output logic [7:0]                o_seg,
  output logic [NUM_DIGITS-1:0]     o_dig_sel,
  output logic                      o_pending,
  output logic                      o_frame_done
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = 4 * NUM_DIGITS;

  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_C = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);
  localparam bit            HAS_GAP = (BLANK_CYCLES > 0);

  localparam logic [7:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] SEL_OFF = (SEL_ACTIVE_LOW != 0) ? '1 : '0;

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic                  boundary;

  logic [DW-1:0]         act_data, pend_data;
  logic [NUM_DIGITS-1:0] act_dp, act_blank, pend_dp, pend_blank;
  logic                  pend_valid;

  logic [3:0]            nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] supp;
  logic [7:0]            seg_raw;
  logic [NUM_DIGITS-1:0] sel_raw;

  function automatic logic [6:0] font(input logic [3:0] n);
    logic [6:0] f;
    f = 7'h00;
    case (n)
      4'h0: f = 7'h3F;  4'h1: f = 7'h06;  4'h2: f = 7'h5B;  4'h3: f = 7'h4F;
      4'h4: f = 7'h66;  4'h5: f = 7'h6D;  4'h6: f = 7'h7D;  4'h7: f = 7'h07;
      4'h8: f = 7'h7F;  4'h9: f = 7'h6F;  4'hA: f = 7'h77;  4'hB: f = 7'h7C;
      4'hC: f = 7'h39;  4'hD: f = 7'h5E;  4'hE: f = 7'h79;  4'hF: f = 7'h71;
      default: f = 7'h00;
    endcase
    return f;
  endfunction

  assign boundary  = (cnt == CNT_MAX) && (idx == IDX_MAX);
  assign o_pending = pend_valid;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
      if (cnt == CNT_MAX)
        idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
    end
  end

  // A load coinciding with the boundary bypasses the pending buffer entirely.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      act_data   <= '0;
      act_dp     <= '0;
      act_blank  <= '0;
      pend_data  <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      pend_valid <= 1'b0;
    end else if (boundary) begin
      pend_valid <= 1'b0;
      if (i_load) begin
        act_data  <= i_data;
        act_dp    <= i_dp;
        act_blank <= i_blank;
      end else if (pend_valid) begin
        act_data  <= pend_data;
        act_dp    <= pend_dp;
        act_blank <= pend_blank;
      end
    end else if (i_load) begin
      pend_data  <= i_data;
      pend_dp    <= i_dp;
      pend_blank <= i_blank;
      pend_valid <= 1'b1;
    end
  end

  // Suppression walks from the most significant digit down; a digit is dark
  // only while every digit above it is dark too.
  always_comb begin
    logic        above_ok;
    int unsigned k;
    above_ok = 1'b1;
    supp     = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++)
      nib[i] = act_data[4*i +: 4];
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      k = NUM_DIGITS - 1 - i;
      supp[k]  = i_lz_en && (k != 0) && (nib[k] == 4'h0) && !act_dp[k] && above_ok;
      above_ok = above_ok && (supp[k] || act_blank[k]);
    end
  end

  always_comb begin
    seg_raw = '0;
    sel_raw = '0;
    if (!(HAS_GAP && (cnt < BLANK_C))) begin
      sel_raw[idx] = 1'b1;
      if (!(act_blank[idx] || supp[idx]))
        seg_raw = {act_dp[idx], font(nib[idx])};
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_seg        <= SEG_OFF;
      o_dig_sel    <= SEL_OFF;
      o_frame_done <= 1'b0;
    end else begin
      o_seg        <= (SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
      o_dig_sel    <= (SEL_ACTIVE_LOW != 0) ? ~sel_raw : sel_raw;
      o_frame_done <= boundary;
    end
  end

endmodule
